// File: rtl/m1_image_loader.sv
// -----------------------------------------------------------------------------
// m1_image_loader
//
// Writer side of the M1 input-image memory. Receives a host stream of 8-bit
// pixels (valid/ready), packs 16 pixels per 128-bit word and writes the words
// to consecutive M1 addresses. After the frame has been written it pulses
// 'start' to the equalization pipeline. It then holds off the next frame until
// the pipeline reports 'pipe_done'.
//
// Parameters
//   IMG_WORDS  128-bit words per frame (16*IMG_WORDS pixels), 1..65536
//   BASE_ADDR  M1 word address of the first image word
//
// Optional feature (build macro LOADER_CHECKSUM_EN)
//   Adds output checksum[15:0]: the sum of the accepted pixels, modulo 2^16.
//   It is cleared when a load is accepted and is valid from START onward.
//   Without the macro there is no port and no adder.
//
// Ports
//   clock            in   system clock, all state on the rising edge
//   reset_n          in   asynchronous active-low reset
//   load             in   1-cycle request to begin receiving a frame
//   in_valid         in   host pixel valid
//   in_pixel[7:0]    in   host pixel value
//   in_last          in   host marks the final pixel of the frame
//   in_ready         out  loader accepts a pixel this cycle (LOAD state only)
//   M1_WriteBus      out  packed word, pixel k at bits [8k+7:8k]
//   M1_WriteAddress  out  word address, BASE_ADDR + word index (wraps mod 2^16)
//   M1_WriteEnable   out  1-cycle write strobe
//   start            out  1-cycle pulse to the equalization pipeline
//   pipe_done        in   pipeline finished processing (level or pulse)
//   busy             out  high in any state other than IDLE
//   short_frame      out  sticky: in_last arrived before the full pixel count
// -----------------------------------------------------------------------------
// State table
//   state   | meaning
//   S_IDLE  | waiting for load; pixels are ignored
//   S_LOAD  | accepting pixels, one per cycle, packing and writing words
//   S_FLUSH | final word write strobe is on the bus
//   S_START | start pulse to the pipeline
//   S_WAIT  | pipeline running; leave on pipe_done
// -----------------------------------------------------------------------------
module m1_image_loader #(
  parameter int          IMG_WORDS = 16384,
  parameter logic [15:0] BASE_ADDR = 16'h0
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic         in_valid,
  input  logic [7:0]   in_pixel,
  input  logic         in_last,
  output logic         in_ready,
  output logic [127:0] M1_WriteBus,
  output logic [15:0]  M1_WriteAddress,
  output logic         M1_WriteEnable,
  output logic         start,
  input  logic         pipe_done,
  output logic         busy,
  output logic         short_frame
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [15:0]  checksum
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  // IMG_WORDS = 65536 gives 16'hFFFF; the index counter then covers all 2^16 words.
  localparam logic [15:0] LAST_IDX = 16'(IMG_WORDS - 1);

  logic [2:0]   r_state;
  logic [3:0]   r_lane;
  logic [15:0]  r_idx;
  logic [127:0] r_pack;
  logic [127:0] r_bus;
  logic [15:0]  r_addr;
  logic         r_we;
  logic         r_short;

  logic         w_accept;
  logic         w_lane_full;
  logic         w_count_end;
  logic         w_word_done;
  logic         w_frame_done;
  logic [127:0] w_word;

  assign w_accept     = in_valid && (r_state == S_LOAD);
  assign w_lane_full  = (r_lane == 4'd15);
  assign w_count_end  = w_lane_full && (r_idx == LAST_IDX);
  assign w_word_done  = w_accept && (w_lane_full || in_last);
  assign w_frame_done = w_accept && (w_count_end || in_last);

  // The pack register is cleared after every word, so lanes above the current
  // one are already zero; a partial word therefore needs no extra masking.
  assign w_word = r_pack | ({120'd0, in_pixel} << {r_lane, 3'b000});

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_lane  <= 4'd0;
      r_idx   <= 16'd0;
      r_pack  <= 128'd0;
      r_bus   <= 128'd0;
      r_addr  <= 16'd0;
      r_we    <= 1'b0;
      r_short <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_state <= S_LOAD;
            r_lane  <= 4'd0;
            r_idx   <= 16'd0;
            r_pack  <= 128'd0;
            r_short <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_word_done) begin
            r_bus  <= w_word;
            r_addr <= BASE_ADDR + r_idx;
            r_we   <= 1'b1;
            r_pack <= 128'd0;
            r_lane <= 4'd0;
            r_idx  <= r_idx + 16'd1;
          end else if (w_accept) begin
            r_pack <= w_word;
            r_lane <= r_lane + 4'd1;
          end
          if (w_frame_done) begin
            r_state <= S_FLUSH;
          end
          // in_last exactly on the last pixel of the last word is a normal end.
          if (w_accept && in_last && !w_count_end) begin
            r_short <= 1'b1;
          end
        end
        S_FLUSH: r_state <= S_START;
        S_START: r_state <= S_WAIT;
        S_WAIT: begin
          if (pipe_done) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] r_sum;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sum <= 16'd0;
    end else if ((r_state == S_IDLE) && load) begin
      r_sum <= 16'd0;
    end else if (w_accept) begin
      r_sum <= r_sum + {8'd0, in_pixel};
    end
  end

  assign checksum = r_sum;
`endif

  assign in_ready        = (r_state == S_LOAD);
  assign M1_WriteBus     = r_bus;
  assign M1_WriteAddress = r_addr;
  assign M1_WriteEnable  = r_we;
  assign start           = (r_state == S_START);
  assign busy            = (r_state != S_IDLE);
  assign short_frame     = r_short;

endmodule

// File: tb/tb_m1_image_loader.sv
module tb_m1_image_loader;

  localparam int IMG_WORDS = 2;
  localparam logic [127:0] W0 = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] W1 = 128'h1f1e1d1c1b1a19181716151413121110;
  localparam logic [127:0] W1_SHORT = 128'h0000_0000_0000_0000_0000_00aa_1312_1110;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic load = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_pixel = 8'd0;
  logic in_last = 1'b0;
  logic pipe_done = 1'b0;

  logic a_ready, a_we, a_start, a_busy, a_short;
  logic [127:0] a_bus;
  logic [15:0] a_addr;
  logic b_ready, b_we, b_start, b_busy, b_short;
  logic [127:0] b_bus;
  logic [15:0] b_addr;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0] a_sum, b_sum;
`endif

  always #5 clock = ~clock;

  m1_image_loader #(.IMG_WORDS(IMG_WORDS), .BASE_ADDR(16'h0000)) dut (
    .clock(clock), .reset_n(reset_n), .load(load), .in_valid(in_valid),
    .in_pixel(in_pixel), .in_last(in_last), .in_ready(a_ready),
    .M1_WriteBus(a_bus), .M1_WriteAddress(a_addr), .M1_WriteEnable(a_we),
    .start(a_start), .pipe_done(pipe_done), .busy(a_busy), .short_frame(a_short)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(a_sum)
`endif
  );

  m1_image_loader #(.IMG_WORDS(IMG_WORDS), .BASE_ADDR(16'hFFFF)) dut_w (
    .clock(clock), .reset_n(reset_n), .load(load), .in_valid(in_valid),
    .in_pixel(in_pixel), .in_last(in_last), .in_ready(b_ready),
    .M1_WriteBus(b_bus), .M1_WriteAddress(b_addr), .M1_WriteEnable(b_we),
    .start(b_start), .pipe_done(pipe_done), .busy(b_busy), .short_frame(b_short)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(b_sum)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks the frame as a list of accepted pixels; words, addresses and the
  // timing of write/start/idle follow from pixel counts and the end cycle.
  int         t = 0;
  bit         m_loading = 0;
  bit         m_active = 0;
  int         m_end_t = -1;
  logic [7:0] m_pix[$];
  bit         m_we = 0;
  bit         m_start = 0;
  bit         m_short = 0;
  int         m_sum = 0;
  logic [127:0] m_word = '0;
  int         m_widx = 0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      t = 0; m_loading = 0; m_active = 0; m_end_t = -1; m_pix.delete();
      m_we = 0; m_start = 0; m_short = 0; m_sum = 0;
    end else begin
      bit prev_loading, prev_active;
      int n;
      t++;
      prev_loading = m_loading;
      prev_active  = m_active;
      m_we = 0;
      if (!prev_active && load) begin
        m_loading = 1; m_active = 1; m_pix.delete(); m_short = 0; m_sum = 0;
      end else if (prev_loading && in_valid) begin
        m_pix.push_back(in_pixel);
        m_sum = (m_sum + in_pixel) % 65536;
        n = m_pix.size();
        if ((n % 16 == 0) || in_last) begin
          m_we = 1;
          m_widx = (n - 1) / 16;
          m_word = '0;
          for (int k = m_widx * 16; k < n; k++) m_word[(k % 16) * 8 +: 8] = m_pix[k];
        end
        if ((n == 16 * IMG_WORDS) || in_last) begin
          m_loading = 0;
          m_end_t = t;
          if (n != 16 * IMG_WORDS) m_short = 1;
        end
      end else if (prev_active && !prev_loading && (m_end_t >= 0) && (t >= m_end_t + 3) && pipe_done) begin
        m_active = 0;
        m_end_t = -1;
      end
      m_start = (m_end_t >= 0) && (t == m_end_t + 1);
    end
  end

  // ---------------- compare process ----------------
  logic [127:0] mem_a[int];
  logic [127:0] mem_b[int];
  int start_cnt = 0;

  always @(negedge clock) begin
    if (reset_n && t > 0) begin
      chk("in_ready", a_ready, m_loading);
      chk("in_ready_w", b_ready, m_loading);
      chk("busy", a_busy, m_active);
      chk("busy_w", b_busy, m_active);
      chk("we", a_we, m_we);
      chk("we_w", b_we, m_we);
      chk("start", a_start, m_start);
      chk("start_w", b_start, m_start);
      chk("short_frame", a_short, m_short);
      chk("short_frame_w", b_short, m_short);
      if (m_we) begin
        chk("bus", a_bus, m_word);
        chk("bus_w", b_bus, m_word);
        chk("addr", a_addr, 16'(m_widx));
        chk("addr_w", b_addr, 16'(32'hFFFF + m_widx));
      end
`ifdef LOADER_CHECKSUM_EN
      if (m_start) begin
        chk("checksum", a_sum, 16'(m_sum));
        chk("checksum_w", b_sum, 16'(m_sum));
      end
`endif
    end
    if (a_we) mem_a[int'(a_addr)] = a_bus;
    if (b_we) mem_b[int'(b_addr)] = b_bus;
    if (a_start) start_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_load();
    load = 1'b1; cyc(1); load = 1'b0;
  endtask

  // Sends pixels 0..n-1 (value at index last_at replaced by last_val and
  // flagged in_last). rnd toggles in_valid randomly.
  task automatic send(input int n, input int last_at, input logic [7:0] last_val, input bit rnd);
    int i = 0;
    int budget = 0;
    bit rdy;
    while (i < n) begin
      in_pixel = (i == last_at) ? last_val : 8'(i);
      in_last  = (i == last_at);
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      rdy = a_ready;
      cyc(1);
      if (in_valid && rdy) i++;
      budget++;
      if (budget > 1000) begin
        chk("send_timeout", 1'b1, 1'b0);
        break;
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic finish_frame();
    int budget = 0;
    pipe_done = 1'b1;
    while (a_busy && budget < 50) begin cyc(1); budget++; end
    pipe_done = 1'b0;
    chk("idle_after_done", a_busy, 1'b0);
  endtask

  initial begin
    #1;
    chk("rst_ready", a_ready, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_we", a_we, 1'b0);
    chk("rst_start", a_start, 1'b0);
    chk("rst_short", a_short, 1'b0);
    chk("rst_bus", a_bus, 128'd0);
    chk("rst_addr", a_addr, 16'd0);
    cyc(3);
    reset_n = 1'b1;
    cyc(2);

    // 1: full frame, extra pixels after count end must not be taken
    mem_a.delete(); mem_b.delete(); start_cnt = 0;
    do_load();
    send(32, -1, 8'h00, 0);
    in_valid = 1'b1; in_pixel = 8'h55; cyc(3); in_valid = 1'b0;
    cyc(2);
    chk("t1_w0", mem_a[0], W0);
    chk("t1_w1", mem_a[1], W1);
    chk("t1_wrap_ffff", mem_b[32'hFFFF], W0);
    chk("t1_wrap_0000", mem_b[0], W1);
    chk("t1_starts", start_cnt, 1);
    chk("t1_short", a_short, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    chk("t1_checksum", a_sum, 16'h01F0);
`endif
    finish_frame();

    // 2: in_last on pixel 20 with value 0xAA
    mem_a.delete(); mem_b.delete(); start_cnt = 0;
    do_load();
    send(21, 20, 8'hAA, 0);
    cyc(4);
    chk("t2_w0", mem_a[0], W0);
    chk("t2_w1", mem_a[1], W1_SHORT);
    chk("t2_short", a_short, 1'b1);
    chk("t2_starts", start_cnt, 1);
    finish_frame();

    // 3: random valid gaps, same memory image as test 1
    mem_a.delete(); mem_b.delete(); start_cnt = 0;
    do_load();
    chk("t3_short_cleared", a_short, 1'b0);
    send(32, -1, 8'h00, 1);
    cyc(4);
    chk("t3_w0", mem_a[0], W0);
    chk("t3_w1", mem_a[1], W1);
    chk("t3_starts", start_cnt, 1);
    finish_frame();

    // 4: reset mid-frame, then a clean reload
    mem_a.delete(); mem_b.delete(); start_cnt = 0;
    do_load();
    send(9, -1, 8'h00, 0);
    reset_n = 1'b0;
    cyc(2);
    chk("t4_writes", mem_a.num(), 0);
    chk("t4_starts", start_cnt, 0);
    chk("t4_busy", a_busy, 1'b0);
    reset_n = 1'b1;
    cyc(2);
    do_load();
    send(32, -1, 8'h00, 0);
    cyc(4);
    chk("t4_w0", mem_a[0], W0);
    chk("t4_starts2", start_cnt, 1);

    // 5: load held in WAIT, then load and pipe_done together
    load = 1'b1;
    cyc(100);
    chk("t5_busy", a_busy, 1'b1);
    chk("t5_ready", a_ready, 1'b0);
    chk("t5_starts", start_cnt, 1);
    pipe_done = 1'b1;
    cyc(1);
    load = 1'b0; pipe_done = 1'b0;
    chk("t5_idle", a_busy, 1'b0);
    cyc(3);
    chk("t5_stay_idle", a_busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
